// File: rtl/draw_rect_ctl.sv
// draw_rect_ctl: moves a 64-px rectangle with the mouse, and on a left-click
// drops it under gravity onto the bottom of a 600-line screen.
//
// Optional feature macro: DRAW_RECT_CTL_BOUNCE_EN
//   defined   -> impacts rebound with 7/8 of the impact speed until the
//                rebound speed falls below V_STOP
//   undefined -> every impact stops the rectangle at the floor
//
// state   | meaning
// --------+---------------------------------------------------------------
// FOLLOW  | rectangle tracks the mouse (y clamped to the floor)
// FALL    | physics running; x frozen, button ignored, update once per tick
// STOPPED | resting on the floor; a new button press returns to FOLLOW
//
// Vertical position is kept as unsigned Q12.8 (y_fp) and velocity as
// signed Q8 px/tick (vel, positive = downward). ypos is the integer part
// of y_fp, so it is a direct slice of a register.
module draw_rect_ctl #(
  parameter int TICK_CYCLES = 40000,
  parameter int GRAVITY     = 16,
  parameter int Y_BOTTOM    = 536,
  parameter int V_STOP      = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos
);

  localparam logic [1:0] FOLLOW  = 2'd0;
  localparam logic [1:0] FALL    = 2'd1;
  localparam logic [1:0] STOPPED = 2'd2;

  // +1 keeps the width non-zero even for TICK_CYCLES == 1
  localparam int CNT_W = $clog2(TICK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  localparam logic        [19:0] Y_BOT_FP = 20'(Y_BOTTOM * 256);
  localparam logic signed [21:0] Y_BOT_S  = $signed({2'b00, Y_BOT_FP});
  localparam logic signed [20:0] GRAV_Q8  = 21'(GRAVITY);

  logic [1:0]        state;
  logic              left_q;
  logic [CNT_W-1:0]  tick_cnt;
  logic [19:0]       y_fp;
  logic signed [20:0] vel;

  logic              left_rise;
  logic              tick;
  logic [19:0]       follow_y;
  logic signed [20:0] vel_n;
  logic signed [21:0] y_n;
  logic              hit_ceiling;
  logic              hit_floor;
  logic              keep_bouncing;
  logic signed [20:0] rebound;

  assign ypos      = y_fp[19:8];
  assign left_rise = mouse_left & ~left_q;
  assign tick      = (tick_cnt == CNT_LAST);

  // Mouse Y in fixed point, limited so the rectangle never leaves the screen
  always_comb begin
    follow_y = {mouse_ypos, 8'h00};
    if ({mouse_ypos, 8'h00} > Y_BOT_FP) begin
      follow_y = Y_BOT_FP;
    end
  end

  // One physics step: gravity first, then move with the new velocity
  always_comb begin
    vel_n       = vel + GRAV_Q8;
    y_n         = $signed({2'b00, y_fp}) + {vel_n[20], vel_n};
    hit_ceiling = (y_n < 22'sd0);
    hit_floor   = (y_n >= Y_BOT_S);
  end

`ifdef DRAW_RECT_CTL_BOUNCE_EN
  logic signed [23:0] vel_x7;

  // Damped rebound speed (7/8 of impact speed) and the decision to keep going
  always_comb begin
    vel_x7        = {{3{vel_n[20]}}, vel_n} * 24'sd7;
    rebound       = 21'(vel_x7 >>> 3);
    keep_bouncing = (rebound >= 21'(V_STOP));
  end
`else
  // Without bounce support every impact is final
  always_comb begin
    rebound       = '0;
    keep_bouncing = 1'b0;
  end
`endif

  // Controller state, button edge register, tick timer and motion registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FOLLOW;
      left_q   <= 1'b1;   // a button held through reset must not count as a press
      tick_cnt <= '0;
      xpos     <= '0;
      y_fp     <= '0;
      vel      <= '0;
    end else begin
      left_q <= mouse_left;
      case (state)
        FOLLOW: begin
          xpos     <= mouse_xpos;
          y_fp     <= follow_y;
          vel      <= '0;
          tick_cnt <= '0;
          if (left_rise) begin
            state <= FALL;
          end
        end

        FALL: begin
          if (tick) begin
            tick_cnt <= '0;
            if (hit_ceiling) begin
              y_fp <= '0;
              vel  <= '0;
            end else if (hit_floor) begin
              y_fp <= Y_BOT_FP;
              if (keep_bouncing) begin
                vel <= -rebound;
              end else begin
                vel   <= '0;
                state <= STOPPED;
              end
            end else begin
              y_fp <= y_n[19:0];
              vel  <= vel_n;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOPPED: begin
          if (left_rise) begin
            state <= FOLLOW;
          end
        end

        default: begin
          state <= FOLLOW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl with a short physics tick (4 cycles).
// Drop from y=0 with gravity 16 (Q8): after k ticks y_fp = 8*k*(k+1),
// so the floor (536<<8 = 137216) is first reached on tick 131.
module tb_draw_rect_ctl;

  localparam int TICK = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos;
  logic [11:0] ypos;

  int n_cmp = 0;
  int n_err = 0;

  draw_rect_ctl #(
    .TICK_CYCLES(TICK),
    .GRAVITY    (16),
    .Y_BOTTOM   (536),
    .V_STOP     (64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mouse_left(mouse_left),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .xpos      (xpos),
    .ypos      (ypos)
  );

  always #5 clk = ~clk;

  // advance n rising edges, then sample 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mouse(input int x, input int y);
    mouse_xpos = 12'(x);
    mouse_ypos = 12'(y);
  endtask

  int          min_y;
  int          run;
  logic [11:0] settled;

  initial begin
    // reset, then follow
    rst = 1'b0;
    mouse_left = 1'b0;
    set_mouse(300, 100);
    step(2);
    chk("rst_x", xpos, 12'd0);
    chk("rst_y", ypos, 12'd0);
    rst = 1'b1;
    step(1);
    chk("follow_x", xpos, 12'd300);
    chk("follow_y", ypos, 12'd100);

    // floor clamp while following
    set_mouse(20, 700);
    step(1);
    chk("clamp_x", xpos, 12'd20);
    chk("clamp_y", ypos, 12'd536);
    set_mouse(5, 535);
    step(1);
    chk("below_floor_y", ypos, 12'd535);

    // button held across reset release must not start a fall
    mouse_left = 1'b1;
    rst = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    set_mouse(77, 88);
    step(10);
    chk("held_rst_x", xpos, 12'd77);
    chk("held_rst_y", ypos, 12'd88);
    mouse_left = 1'b0;
    step(1);

    // drop from the top
    set_mouse(400, 0);
    step(1);
    mouse_left = 1'b1;
    step(1);
    chk("drop_x", xpos, 12'd400);
    chk("drop_y0", ypos, 12'd0);
    mouse_left = 1'b0;
    step(TICK);
    chk("tick1_y", ypos, 12'd0);

    // button toggles and mouse moves during the fall are ignored
    mouse_left = 1'b1;
    set_mouse(100, 300);
    step(9 * TICK);
    chk("tick10_x", xpos, 12'd400);
    chk("tick10_y", ypos, 12'd3);
    mouse_left = 1'b0;
    step(40 * TICK);
    chk("tick50_y", ypos, 12'd79);
    mouse_left = 1'b1;
    set_mouse(0, 0);
    step(50 * TICK);
    chk("tick100_y", ypos, 12'd315);
    chk("tick100_x", xpos, 12'd400);
    mouse_left = 1'b0;
    step(30 * TICK);
    chk("tick130_y", ypos, 12'd532);
    step(TICK);
    chk("impact_y", ypos, 12'd536);

`ifdef DRAW_RECT_CTL_BOUNCE_EN
    // rebound at -1834 (Q8): first step up lands at 135398 -> 528
    step(TICK);
    chk("rebound1_y", ypos, 12'd528);
    // apex 114 ticks after impact: 33020 -> 128
    step(113 * TICK);
    chk("apex_y", ypos, 12'd128);
    // bounces decay; eventually rests at the floor for good
    run = 0;
    settled = 12'd0;
    for (int i = 0; i < 4000; i++) begin
      step(TICK);
      if (ypos == 12'd536) run++;
      else run = 0;
      if (run >= 300) begin
        settled = 12'd1;
        break;
      end
    end
    chk("bounce_settled", settled, 12'd1);
`else
    // no rebound: stays at the floor
    min_y = 4095;
    for (int i = 0; i < 200; i++) begin
      step(TICK);
      if (int'(ypos) < min_y) min_y = int'(ypos);
    end
    chk("nobounce_min_y", 12'(min_y), 12'd536);
`endif

    // stopped: holds position, mouse ignored until a new press
    set_mouse(10, 10);
    step(8);
    chk("stopped_x", xpos, 12'd400);
    chk("stopped_y", ypos, 12'd536);
    mouse_left = 1'b1;
    step(2);
    chk("refollow_x", xpos, 12'd10);
    chk("refollow_y", ypos, 12'd10);

    // mid-fall reset with the button held
    mouse_left = 1'b0;
    step(1);
    set_mouse(400, 0);
    step(1);
    mouse_left = 1'b1;
    step(1);
    step(100 * TICK);
    chk("midfall_y", ypos, 12'd315);
    set_mouse(123, 45);
    rst = 1'b0;
    step(1);
    chk("midrst_x", xpos, 12'd0);
    chk("midrst_y", ypos, 12'd0);
    rst = 1'b1;
    step(1);
    chk("postrst_x", xpos, 12'd123);
    chk("postrst_y", ypos, 12'd45);
    step(10 * TICK);
    set_mouse(124, 46);
    step(1);
    chk("noretrig_x", xpos, 12'd124);
    chk("noretrig_y", ypos, 12'd46);
    mouse_left = 1'b0;
    step(1);
    mouse_left = 1'b1;
    step(1);
    set_mouse(200, 200);
    step(1);
    chk("refall_x", xpos, 12'd124);
    chk("refall_y", ypos, 12'd46);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
